cpu_nbits_core: RTL and testbench

- Parametrised, handshaked successor to the fixed 3-input datapath.
- Accepts encoded commands over a valid/ready interface and selects two operands from N_IN external inputs or from the result register (feedback).
- Executes ADD/SUB/AND/OR in one cycle and MUL in multiple cycles with an iterative shift-add unit.
- Stores and loads 2*WIDTH results to and from an internal memory of 2**ADDR_W words, and reports zero/error flags.

---
 rtl/cpu_nbits_core.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_nbits_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_nbits_core.sv
// Parametrised handshaked datapath core: operand select, ALU,
// iterative shift-add multiplier and a small result memory.
module cpu_nbits_core #(
  parameter int WIDTH  = 8,
  parameter int N_IN   = 3,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = $clog2(N_IN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3+2*SEL_W-1:0]    cmd,
  input  logic [N_IN*WIDTH-1:0]   din,
  input  logic [ADDR_W-1:0]       addr,
  output logic [WIDTH-1:0]        dout_low,
  output logic [WIDTH-1:0]        dout_high,
  output logic                    res_valid,
  output logic                    zero,
  output logic                    error
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MUL,
    S_MEMRD
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bad_q;
  logic [W2-1:0]     res_q;
  logic [W2-1:0]     acc_q, mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CW-1:0]     cnt_q;
  logic              rd_ph_q;
  logic [W2-1:0]     rdata_q;
  logic              ready_q, rv_q, zero_q, err_q;

  logic [W2-1:0] mem [2**ADDR_W];

  logic [2:0]       op_in;
  logic [SEL_W-1:0] sa_in, sb_in;
  logic [WIDTH-1:0] a_in, b_in;
  logic             bad_in, accept;

  assign op_in  = cmd[3+2*SEL_W-1 -: 3];
  assign sa_in  = cmd[2*SEL_W-1 -: SEL_W];
  assign sb_in  = cmd[SEL_W-1:0];
  assign accept = cmd_valid & ready_q;

  // Select N_IN means feedback from the result register.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(sa_in) == k) a_in = din[k*WIDTH +: WIDTH];
      if (int'(sb_in) == k) b_in = din[k*WIDTH +: WIDTH];
    end
    if (int'(sa_in) == N_IN) a_in = res_q[W2-1:WIDTH];
    if (int'(sb_in) == N_IN) b_in = res_q[WIDTH-1:0];
    bad_in = (op_in == OP_ILL) ||
             (int'(sa_in) > N_IN) ||
             (int'(sb_in) > N_IN);
  end

  logic [W2-1:0] a_ext, b_ext, alu;

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    alu = '0;
    unique case (op_q)
      OP_ADD:  alu = a_ext + b_ext;
      OP_SUB:  alu = a_ext - b_ext;
      OP_AND:  alu = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   alu = {{WIDTH{1'b0}}, a_q | b_q};
      default: alu = '0;
    endcase
  end

  logic          done, wr_res, err_new, mul_last, mem_we;
  logic [W2-1:0] res_new;

  assign mul_last = (cnt_q == CW'(WIDTH));
  assign mem_we   = (state_q == S_EXEC) && !bad_q && (op_q == OP_ST);
  assign err_new  = (state_q == S_EXEC) && bad_q;

  always_comb begin
    done    = 1'b0;
    wr_res  = 1'b0;
    res_new = alu;
    unique case (state_q)
      S_EXEC: begin
        done   = 1'b1;
        wr_res = !bad_q && (op_q == OP_ADD || op_q == OP_SUB ||
                            op_q == OP_AND || op_q == OP_OR);
      end
      S_MUL: begin
        done    = mul_last;
        wr_res  = mul_last;
        res_new = acc_q;
      end
      S_MEMRD: begin
        done    = rd_ph_q;
        wr_res  = rd_ph_q;
        res_new = rdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: begin
        if (bad_q)               state_d = S_EXEC;
        else if (op_q == OP_MUL) state_d = S_MUL;
        else if (op_q == OP_LD)  state_d = S_MEMRD;
        else                     state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_IDLE;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      S_MEMRD: if (rd_ph_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      bad_q    <= 1'b0;
      res_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rd_ph_q  <= 1'b0;
      rv_q     <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rv_q <= done;
      if (accept) begin
        op_q   <= op_in;
        a_q    <= a_in;
        b_q    <= b_in;
        addr_q <= addr;
        bad_q  <= bad_in;
      end
      if (state_q == S_FETCH) begin
        acc_q    <= '0;
        mcand_q  <= a_ext;
        mplier_q <= b_q;
        cnt_q    <= '0;
        rd_ph_q  <= 1'b0;
      end
      if (state_q == S_MUL && !mul_last) begin
        acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (state_q == S_MEMRD) rd_ph_q <= 1'b1;
      if (done) begin
        err_q <= err_new;
        if (wr_res) begin
          res_q  <= res_new;
          zero_q <= (res_new == '0);
        end
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= res_q;
    if (state_q == S_MEMRD) rdata_q <= mem[addr_q];
  end

  assign cmd_ready = ready_q;
  assign dout_low  = res_q[WIDTH-1:0];
  assign dout_high = res_q[W2-1:WIDTH];
  assign res_valid = rv_q;
  assign zero      = zero_q;
  assign error     = err_q;

endmodule

// File: tb/tb_cpu_nbits_core.sv
// Scoreboard bench for cpu_nbits_core: directed plan, random
// commands against a high-level model, and a reset-abort case.
module tb_cpu_nbits_core;

  localparam int WIDTH  = 8;
  localparam int N_IN   = 3;
  localparam int ADDR_W = 4;
  localparam int SEL_W  = 2;

  localparam logic [2:0] ADD = 0, SUB = 1, MUL = 2, AND = 3;
  localparam logic [2:0] OR = 4, ST = 5, LD = 6, ILL = 7;

  logic                  clk = 0;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3+2*SEL_W-1:0]  cmd;
  logic [N_IN*WIDTH-1:0] din;
  logic [ADDR_W-1:0]     addr;
  logic [WIDTH-1:0]      dout_low, dout_high;
  logic                  res_valid, zero, error;

  cpu_nbits_core #(
    .WIDTH(WIDTH), .N_IN(N_IN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .din(din), .addr(addr),
    .dout_low(dout_low), .dout_high(dout_high),
    .res_valid(res_valid), .zero(zero), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        e;
    int          t;
  } exp_t;

  exp_t sb_q[$];
  exp_t me;

  int n_cmp = 0;
  int n_bad = 0;
  bit abort = 0;

  logic [15:0] m_res;
  logic        m_zero, m_err;
  logic [15:0] m_mem[16];
  bit          m_val[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: results follow directly from the opcode rules.
  task automatic model(input logic [2:0] op, input logic [1:0] sa,
                       input logic [1:0] sbs, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2,
                       input logic [3:0] ad, input int t0);
    logic [7:0]  dv[3];
    logic [15:0] a, b, r;
    int          lat;
    exp_t        e;
    dv  = '{d0, d1, d2};
    a   = (sa < 3) ? {8'h0, dv[sa]} : {8'h0, m_res[15:8]};
    b   = (sbs < 3) ? {8'h0, dv[sbs]} : {8'h0, m_res[7:0]};
    r   = m_res;
    lat = 2;
    case (op)
      ADD: r = a + b;
      SUB: r = a - b;
      MUL: begin r = a * b; lat = WIDTH + 2; end
      AND: r = a & b;
      OR:  r = a | b;
      ST:  begin m_mem[ad] = m_res; m_val[ad] = 1; end
      LD:  begin r = m_mem[ad]; lat = 3; end
      default: ;
    endcase
    m_err = (op == ILL);
    if (op != ST && op != ILL) begin
      m_res  = r;
      m_zero = (r == 0);
    end
    e.res = m_res;
    e.z   = m_zero;
    e.e   = m_err;
    e.t   = t0 + lat;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] sa,
                       input logic [1:0] sbs, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2,
                       input logic [3:0] ad, output int t0);
    int n;
    t0 = -1;
    if (abort) return;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      cmd_valid = 1'($urandom);
      cmd       = 7'($urandom);
      din       = 24'($urandom);
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 0, 1);
      abort = 1;
      return;
    end
    t0 = cyc + 1;
    model(op, sa, sbs, d0, d1, d2, ad, t0);
    cmd_valid = 1;
    cmd       = {op, sa, sbs};
    din       = {d2, d1, d0};
    addr      = ad;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd       = 7'($urandom);
    din       = 24'($urandom);
    addr      = 4'($urandom);
    chk("ready_busy", cmd_ready, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", sb_q.size(), 0);
  endtask

  function automatic logic [7:0] rbyte();
    return ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && res_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_res_valid", 1, 0);
      end else begin
        me = sb_q.pop_front();
        chk("result", {dout_high, dout_low}, me.res);
        chk("zero", zero, me.z);
        chk("error", error, me.e);
        chk("latency", cyc, me.t);
      end
    end
  end

  initial begin
    int t0;
    logic [2:0] op;
    logic [3:0] ad;
    rst = 0; cmd_valid = 0; cmd = 0; din = 0; addr = 0;
    m_res = 0; m_zero = 0; m_err = 0;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {dout_high, dout_low}, 0);
    chk("rst_zero", zero, 0);
    chk("rst_error", error, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    issue(ADD, 0, 1, 200, 100, 0, 0, t0);
    issue(MUL, 0, 2, 255, 0, 255, 0, t0);
    drain();
    chk("mul_ffxff", {dout_high, dout_low}, 16'hFE01);
    issue(SUB, 1, 1, 0, 5, 0, 0, t0);
    issue(SUB, 0, 1, 3, 5, 0, 0, t0);
    issue(ADD, 0, 1, 200, 100, 0, 0, t0);
    issue(ADD, 3, 3, 0, 0, 0, 0, t0);
    issue(ST, 0, 0, 0, 0, 0, 7, t0);
    issue(AND, 0, 1, 8'h0F, 8'hF0, 0, 0, t0);
    issue(LD, 0, 0, 0, 0, 0, 7, t0);
    issue(ILL, 0, 0, 0, 0, 0, 0, t0);
    issue(ADD, 0, 1, 1, 1, 0, 0, t0);
    drain();
    chk("add_1_1", {dout_high, dout_low}, 16'h0002);

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom);
      ad = 4'($urandom);
      if (op == LD && !m_val[ad]) op = ADD;
      issue(op, 2'($urandom), 2'($urandom),
            rbyte(), rbyte(), rbyte(), ad, t0);
    end
    drain();

    issue(MUL, 0, 1, 8'd77, 8'd91, 0, 0, t0);
    if (t0 >= 0) begin
      while (cyc < t0 + 5) begin
        @(posedge clk);
        #1;
      end
      rst = 0;
      #1;
      chk("abort_dout", {dout_high, dout_low}, 0);
      chk("abort_zero", zero, 0);
      chk("abort_error", error, 0);
      chk("abort_res_valid", res_valid, 0);
      sb_q.delete();
      m_res = 0; m_zero = 0; m_err = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      chk("ready_after_abort", cmd_ready, 1);
      issue(ADD, 0, 1, 1, 1, 0, 0, t0);
      drain();
      chk("post_abort_add", {dout_high, dout_low}, 16'h0002);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
